// File: rtl/cr_huf_comp_freq_scan_ctrl.sv
// Frequency-table scan controller: on a block-end strobe, reads the frequency snapshot
// for the used symbol range lo..hi and streams (symbol, frequency) beats downstream.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module cr_huf_comp_freq_scan_ctrl #(
  parameter int unsigned DAT_WIDTH        = 10,
  parameter int unsigned SYM_FREQ_WIDTH   = 15,
  parameter int unsigned CNTRL_WIDTH      = 1,
  parameter int unsigned MAX_NUM_SYM_USED = 576
) (
  input  logic                              clk_gated,
  input  logic                              rst_n,
  input  logic                              is_eob_vld,
  input  logic                              is_sym_any,
  input  logic [DAT_WIDTH-1:0]              is_sym_lo,
  input  logic [DAT_WIDTH-1:0]              is_sym_hi,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] is_seq_id,
  input  logic [CNTRL_WIDTH-1:0]            is_meta,
  output logic                              not_ready,
  output logic                              freq_rd_en,
  output logic [DAT_WIDTH-1:0]              freq_rd_addr,
  input  logic [SYM_FREQ_WIDTH-1:0]         freq_rd_data,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [DAT_WIDTH-1:0]              out_sym,
  output logic [SYM_FREQ_WIDTH-1:0]         out_freq,
  output logic                              out_last,
  output logic                              out_empty,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0] out_seq_id,
  output logic [CNTRL_WIDTH-1:0]            out_meta,
  output logic                              ovr_err
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  typedef struct packed {
    logic [DAT_WIDTH-1:0]      sym;
    logic [SYM_FREQ_WIDTH-1:0] freq;
    logic                      last;
    logic                      empty;
  } beat_t;

  state_e                              state_q, state_d;
  logic [DAT_WIDTH-1:0]                addr_q, hi_q, rd_sym_q;
  logic                                any_q, rd_pend_q, ovr_q;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0]   seq_q;
  logic [CNTRL_WIDTH-1:0]              meta_q;
  beat_t                               fifo_q [2];
  logic                                wr_ptr_q, rd_ptr_q;
  logic [1:0]                          cnt_q;

  logic  credit, rd_en, push_empty, inc_vld, push, pop, xfer, vld, at_end;
  beat_t inc, head;

  // Reads return next cycle, so one pending read plus FIFO occupancy bounds buffering to 2.
  assign credit     = (2'(rd_pend_q) + cnt_q) < 2'd2;
  assign rd_en      = (state_q == StScan) & any_q & credit;
  assign push_empty = (state_q == StScan) & ~any_q;
  assign at_end     = (addr_q == hi_q) || (addr_q == DAT_WIDTH'(MAX_NUM_SYM_USED - 1));

  always_comb begin
    inc = '0;
    if (push_empty) begin
      inc.last  = 1'b1;
      inc.empty = 1'b1;
    end else begin
      inc.sym  = rd_sym_q;
      inc.freq = freq_rd_data;
      inc.last = (rd_sym_q == hi_q);
    end
  end

  // Fall-through: with an empty FIFO the returning read is presented directly.
  assign inc_vld = rd_pend_q | push_empty;
  assign vld     = (cnt_q != 2'd0) | inc_vld;
  assign head    = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : inc;
  assign xfer    = vld & out_rdy;
  assign pop     = xfer & (cnt_q != 2'd0);
  assign push    = inc_vld & ~(xfer & (cnt_q == 2'd0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_eob_vld) state_d = StScan;
      StScan: begin
        if (!any_q)               state_d = out_rdy ? StIdle : StDrain;
        else if (rd_en && at_end) state_d = StDrain;
      end
      StDrain: if (xfer && head.last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      hi_q      <= '0;
      any_q     <= 1'b0;
      seq_q     <= '0;
      meta_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_sym_q  <= '0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ovr_q     <= is_eob_vld & (state_q != StIdle);
      rd_pend_q <= rd_en;
      if (state_q == StIdle && is_eob_vld) begin
        addr_q <= is_sym_lo;
        hi_q   <= is_sym_hi;
        any_q  <= is_sym_any;
        seq_q  <= is_seq_id;
        meta_q <= is_meta;
      end else if (rd_en) begin
        rd_sym_q <= addr_q;
        if (!at_end) addr_q <= addr_q + 1'b1;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= inc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign not_ready    = (state_q != StIdle);
  assign freq_rd_en   = rd_en;
  assign freq_rd_addr = rd_en ? addr_q : '0;
  assign out_vld      = vld;
  assign out_sym      = vld ? head.sym : '0;
  assign out_freq     = vld ? head.freq : '0;
  assign out_last     = vld & head.last;
  assign out_empty    = vld & head.empty;
  assign out_seq_id   = vld ? seq_q : '0;
  assign out_meta     = vld ? meta_q : '0;
  assign ovr_err      = ovr_q;

endmodule

// File: tb/tb_cr_huf_comp_freq_scan_ctrl.sv
// Directed, table-driven bench for the frequency scan controller with a
// one-cycle-latency frequency memory model and a beat/read scoreboard.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module tb_cr_huf_comp_freq_scan_ctrl;
  localparam int DW = 10;
  localparam int FW = 15;
  localparam int SW = `CREOLE_HC_SEQID_WIDTH;

  logic          clk_gated = 1'b0;
  logic          rst_n = 1'b0;
  logic          is_eob_vld = 1'b0, is_sym_any = 1'b0;
  logic [DW-1:0] is_sym_lo = '0, is_sym_hi = '0;
  logic [SW-1:0] is_seq_id = '0;
  logic [0:0]    is_meta = '0;
  logic          not_ready, freq_rd_en, out_vld, out_last, out_empty, ovr_err;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] freq_rd_addr, out_sym;
  logic [FW-1:0] freq_rd_data = '0, out_freq;
  logic [SW-1:0] out_seq_id;
  logic [0:0]    out_meta;

  cr_huf_comp_freq_scan_ctrl dut (
    .clk_gated(clk_gated), .rst_n(rst_n), .is_eob_vld(is_eob_vld), .is_sym_any(is_sym_any),
    .is_sym_lo(is_sym_lo), .is_sym_hi(is_sym_hi), .is_seq_id(is_seq_id), .is_meta(is_meta),
    .not_ready(not_ready), .freq_rd_en(freq_rd_en), .freq_rd_addr(freq_rd_addr),
    .freq_rd_data(freq_rd_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_sym(out_sym),
    .out_freq(out_freq), .out_last(out_last), .out_empty(out_empty), .out_seq_id(out_seq_id),
    .out_meta(out_meta), .ovr_err(ovr_err)
  );

  always #5 clk_gated = ~clk_gated;

  typedef struct {int lo; int hi; bit any; bit zero; int stall; int ovr;} vec_t;
  typedef struct {int sym; int freq; bit last; bit empty; int seq; int meta; int cyc;} beat_t;
  typedef struct {int addr; int cyc;} rd_t;

  int    n_checks = 0, n_err = 0, cyc = 0;
  bit    zero_mode = 1'b0, done = 1'b0;
  beat_t beat_q[$];
  rd_t   rd_q[$];
  int    ovr_cnt = 0, rd_tot = 0, bt_tot = 0;
  bit    prev_stall = 1'b0;
  logic [DW+FW+SW+3-1:0] prev_pay;

  function automatic int fmodel(int a);
    if (zero_mode && a[0] == 1'b0) return 0;
    return (a + 1) & 16'h7fff;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_gated) begin
    cyc <= cyc + 1;
    freq_rd_data <= freq_rd_en ? FW'(fmodel(int'(freq_rd_addr))) : 15'h7abc;
  end

  // Scoreboard capture plus credit and hold-stability checks.
  always @(negedge clk_gated) begin
    if (freq_rd_en) rd_q.push_back('{int'(freq_rd_addr), cyc});
    if (ovr_err) ovr_cnt++;
    if (rst_n) begin
      if (freq_rd_en) begin
        rd_tot++;
        check("outstanding_le2", rd_tot - bt_tot, (rd_tot - bt_tot > 2) ? 2 : rd_tot - bt_tot);
      end
      if (prev_stall) begin
        check("hold_vld", int'(out_vld), 1);
        check("hold_payload", int'(prev_pay == {out_sym, out_freq, out_seq_id, out_meta,
                                                out_last, out_empty}), 1);
      end
      prev_stall = out_vld & ~out_rdy;
      prev_pay   = {out_sym, out_freq, out_seq_id, out_meta, out_last, out_empty};
      if (out_vld && out_rdy) begin
        bt_tot++;
        beat_q.push_back('{int'(out_sym), int'(out_freq), out_last, out_empty,
                           int'(out_seq_id), int'(out_meta), cyc});
        if (out_last) done = 1'b1;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_not_ready"}, int'(not_ready), 0);
    check({tag, "_rd_en"}, int'(freq_rd_en), 0);
    check({tag, "_rd_addr"}, int'(freq_rd_addr), 0);
    check({tag, "_out_vld"}, int'(out_vld), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_out_empty"}, int'(out_empty), 0);
    check({tag, "_ovr_err"}, int'(ovr_err), 0);
    check({tag, "_payload"}, int'(out_sym) + int'(out_freq) + int'(out_seq_id) + int'(out_meta), 0);
  endtask

  task automatic run_block(vec_t v, int seq, int meta);
    int eob_cyc, vc, nexp;
    beat_q.delete(); rd_q.delete();
    ovr_cnt = 0; rd_tot = 0; bt_tot = 0; done = 1'b0; vc = 0;
    zero_mode = v.zero;
    @(posedge clk_gated); #1;
    is_eob_vld = 1'b1; is_sym_lo = DW'(v.lo); is_sym_hi = DW'(v.hi); is_sym_any = v.any;
    is_seq_id = SW'(seq); is_meta = 1'(meta); out_rdy = (v.stall == 0);
    eob_cyc = cyc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk_gated); #1;
      is_eob_vld = 1'b0;
      if (cyc == eob_cyc + 1) check("not_ready_scan", int'(not_ready), 1);
      if (out_vld) vc++;
      out_rdy = (vc > v.stall);
      if (v.ovr == 1 && cyc == eob_cyc + 2) begin
        is_eob_vld = 1'b1; is_sym_lo = 10'd100; is_sym_hi = 10'd200; is_seq_id = ~SW'(seq);
      end
      if (v.ovr == 2 && out_vld && out_rdy && out_last) is_eob_vld = 1'b1;
    end
    if (!done) check("block_timeout", 0, 1);
    out_rdy = 1'b1;
    @(posedge clk_gated); #1;
    is_eob_vld = 1'b0;
    check("idle_not_ready", int'(not_ready), 0);
    check("idle_out_vld", int'(out_vld), 0);
    repeat (2) @(posedge clk_gated);
    #1;
    check("ovr_pulses", ovr_cnt, (v.ovr != 0) ? 1 : 0);
    nexp = v.any ? v.hi - v.lo + 1 : 1;
    check("beat_count", beat_q.size(), nexp);
    check("read_count", rd_q.size(), v.any ? nexp : 0);
    for (int i = 0; i < nexp && i < beat_q.size(); i++) begin
      int a = v.lo + i;
      check("beat_sym", beat_q[i].sym, v.any ? a : 0);
      check("beat_freq", beat_q[i].freq, v.any ? fmodel(a) : 0);
      check("beat_last", int'(beat_q[i].last), (!v.any || a == v.hi) ? 1 : 0);
      check("beat_empty", int'(beat_q[i].empty), v.any ? 0 : 1);
      check("beat_seq", beat_q[i].seq, seq);
      check("beat_meta", beat_q[i].meta, meta);
      if (v.any && v.stall == 0) check("beat_cycle", beat_q[i].cyc - eob_cyc, i + 2);
    end
    for (int i = 0; i < rd_q.size() && i < nexp && v.any; i++) begin
      check("read_addr", rd_q[i].addr, v.lo + i);
      if (v.stall == 0) check("read_cycle", rd_q[i].cyc - eob_cyc, i + 1);
    end
  endtask

  vec_t vecs[7];
  int   nb, nr;

  initial begin
    vecs[0] = '{lo: 3,   hi: 6,   any: 1, zero: 0, stall: 0, ovr: 0};
    vecs[1] = '{lo: 3,   hi: 6,   any: 1, zero: 0, stall: 5, ovr: 0};
    vecs[2] = '{lo: 7,   hi: 9,   any: 0, zero: 0, stall: 0, ovr: 0};
    vecs[3] = '{lo: 575, hi: 575, any: 1, zero: 0, stall: 0, ovr: 0};
    vecs[4] = '{lo: 10,  hi: 17,  any: 1, zero: 1, stall: 3, ovr: 0};
    vecs[5] = '{lo: 3,   hi: 6,   any: 1, zero: 0, stall: 0, ovr: 1};
    vecs[6] = '{lo: 570, hi: 575, any: 1, zero: 0, stall: 2, ovr: 2};

    repeat (3) @(posedge clk_gated);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk_gated); #1;
    check_reset_outputs("post_reset");

    for (int k = 0; k < 7; k++) run_block(vecs[k], k + 1, k & 1);

    // Empty block with a stalled sink: the single beat must wait, then return to idle.
    run_block('{lo: 0, hi: 0, any: 0, zero: 0, stall: 3, ovr: 0}, 9, 1);

    // Reset in the middle of a 10-beat block.
    beat_q.delete(); rd_q.delete(); done = 1'b0; zero_mode = 1'b0;
    @(posedge clk_gated); #1;
    is_eob_vld = 1'b1; is_sym_lo = 10'd20; is_sym_hi = 10'd29; is_sym_any = 1'b1; out_rdy = 1'b1;
    @(posedge clk_gated); #1;
    is_eob_vld = 1'b0;
    for (int i = 0; i < 50 && beat_q.size() < 2; i++) begin
      @(posedge clk_gated); #1;
    end
    check("mid_beats_before_reset", beat_q.size(), 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    nb = beat_q.size(); nr = rd_q.size();
    repeat (3) @(posedge clk_gated);
    #1;
    check("no_beats_in_reset", beat_q.size(), nb);
    check("no_reads_in_reset", rd_q.size(), nr);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_gated);
    #1;
    check("after_reset_idle", int'(not_ready) + int'(out_vld) + int'(freq_rd_en), 0);
    run_block('{lo: 40, hi: 42, any: 1, zero: 0, stall: 0, ovr: 0}, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
